// File: rtl/spi_adc_reader.sv
// SPI master that reads fixed-length frames from a serial ADC and extracts a data field.
// Supports single-shot and continuous conversion with a start/busy/valid handshake.
module spi_adc_reader #(
  parameter int CLKS_PER_HALF_BIT = 5,
  parameter int CPOL              = 1,
  parameter int CPHA              = 1,
  parameter int FRAME_BITS        = 16,
  parameter int DATA_MSB          = 12,
  parameter int DATA_LSB          = 5,
  parameter int CS_SETUP_CLKS     = 1,
  parameter int QUIET_CLKS        = 7
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst,
  input  logic                         i_Start,
  input  logic                         i_Continuous,
  output logic                         o_Busy,
  output logic [DATA_MSB-DATA_LSB:0]   o_Data,
  output logic [FRAME_BITS-1:0]        o_Frame,
  output logic                         o_Data_Valid,
  output logic                         o_SPI_Clk,
  output logic                         o_SPI_CS_n,
  output logic                         o_SPI_MOSI,
  input  logic                         i_SPI_MISO,
  output logic [1:0]                   o_State
);

  // Handshake: i_Start is a one-cycle request; o_Busy is high from the cycle after an
  // accepted request until IDLE is re-entered; o_Data_Valid pulses once per completed
  // frame, on the first cycle CS_n is high again, and o_Data/o_Frame hold until the next.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    QUIET = 2'd3
  } state_t;

  localparam logic [15:0] HALF_LAST  = 16'(CLKS_PER_HALF_BIT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP_CLKS - 1);
  localparam logic [15:0] QUIET_LAST = 16'(QUIET_CLKS - 1);
  localparam logic [7:0]  EDGES_ALL  = 8'(2 * FRAME_BITS);

  state_t                  state, state_nxt;
  logic [15:0]             cnt;
  logic [7:0]              edges;
  logic                    pending;
  logic                    sclk;
  logic [FRAME_BITS-1:0]   shift_q;
  logic                    toggle;
  logic                    sample;
  logic                    done;
  logic                    enter_setup;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    toggle      = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:  if (i_Start || i_Continuous || pending) state_nxt = SETUP;
      SETUP: if (cnt == SETUP_LAST) state_nxt = SHIFT;
      SHIFT: begin
        if (cnt == HALF_LAST) begin
          if (edges == EDGES_ALL) begin
            state_nxt = QUIET;
            done      = 1'b1;
          end else begin
            toggle = 1'b1;
          end
        end
      end
      QUIET: if (cnt == QUIET_LAST) state_nxt = (i_Continuous || pending) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_setup = (state_nxt == SETUP) && (state != SETUP);
    // edges counts toggles already made, so an even count means the next one is leading.
    sample      = toggle && ((CPHA != 0) ? edges[0] : ~edges[0]);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt          <= '0;
      edges        <= '0;
      pending      <= 1'b0;
      sclk         <= 1'(CPOL);
      shift_q      <= '0;
      o_Frame      <= '0;
      o_Data       <= '0;
      o_Data_Valid <= 1'b0;
    end else begin
      o_Data_Valid <= done;
      if (state_nxt != state || state == IDLE || toggle) cnt <= '0;
      else                                               cnt <= cnt + 16'd1;
      if (state != SHIFT) edges <= '0;
      else if (toggle)    edges <= edges + 8'd1;
      if (toggle) sclk <= ~sclk;
      if (sample) shift_q <= {shift_q[FRAME_BITS-2:0], i_SPI_MISO};
      if (done) begin
        o_Frame <= shift_q;
        o_Data  <= shift_q[DATA_MSB:DATA_LSB];
      end
      if (enter_setup)                    pending <= 1'b0;
      else if (i_Start && state != IDLE)  pending <= 1'b1;
    end
  end

  assign o_Busy     = (state != IDLE);
  assign o_SPI_CS_n = ~((state == SETUP) || (state == SHIFT));
  assign o_SPI_Clk  = sclk;
  assign o_SPI_MOSI = 1'b0;
  assign o_State    = state;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Bench for spi_adc_reader: three parameterisations driven by a shared ADC slave model,
// a vector table of single-shot frames and hand-written multi-cycle sequences.
module tb_spi_adc_reader;

  localparam int FB_I[3]   = '{16, 12, 16};
  localparam int CPHA_I[3] = '{1, 0, 1};
  localparam int CPOL_I[3] = '{1, 0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst[3], start[3], cont[3], miso[3];
  logic       busy[3], valid[3], sclk[3], cs_n[3], mosi[3];
  logic [1:0] st[3];
  logic [7:0] data[3];
  logic [15:0] frame_a, frame_c;
  logic [11:0] frame_b;

  spi_adc_reader dut_a (
    .i_Clk(clk), .i_Rst(rst[0]), .i_Start(start[0]), .i_Continuous(cont[0]),
    .o_Busy(busy[0]), .o_Data(data[0]), .o_Frame(frame_a), .o_Data_Valid(valid[0]),
    .o_SPI_Clk(sclk[0]), .o_SPI_CS_n(cs_n[0]), .o_SPI_MOSI(mosi[0]),
    .i_SPI_MISO(miso[0]), .o_State(st[0]));

  spi_adc_reader #(.CPOL(0), .CPHA(0), .FRAME_BITS(12), .DATA_MSB(11), .DATA_LSB(4)) dut_b (
    .i_Clk(clk), .i_Rst(rst[1]), .i_Start(start[1]), .i_Continuous(cont[1]),
    .o_Busy(busy[1]), .o_Data(data[1]), .o_Frame(frame_b), .o_Data_Valid(valid[1]),
    .o_SPI_Clk(sclk[1]), .o_SPI_CS_n(cs_n[1]), .o_SPI_MOSI(mosi[1]),
    .i_SPI_MISO(miso[1]), .o_State(st[1]));

  spi_adc_reader #(.CLKS_PER_HALF_BIT(2), .CS_SETUP_CLKS(3)) dut_c (
    .i_Clk(clk), .i_Rst(rst[2]), .i_Start(start[2]), .i_Continuous(cont[2]),
    .o_Busy(busy[2]), .o_Data(data[2]), .o_Frame(frame_c), .o_Data_Valid(valid[2]),
    .o_SPI_Clk(sclk[2]), .o_SPI_CS_n(cs_n[2]), .o_SPI_MOSI(mosi[2]),
    .i_SPI_MISO(miso[2]), .o_State(st[2]));

  int n_cmp = 0;
  int n_bad = 0;
  logic [25:0] exp_q[$];

  function automatic logic [15:0] frame_of(int i);
    if (i == 0) return frame_a;
    if (i == 1) return {4'h0, frame_b};
    return frame_c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ADC slave model plus per-instance observers, all evaluated on the falling clock edge
  logic [15:0] slave_frame[3];
  int  s_edges[3], samp_cnt[3], samp_rise[3];
  logic prev_sclk[3], prev_cs[3], prev_busy[3];
  int  low_run[3], low_len[3], fall_cyc[3], fall_gap[3], busy_fall[3];
  int  valid_cnt[3], valid_cyc[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      slave_frame[i] = '0; s_edges[i] = 0; samp_cnt[i] = 0; samp_rise[i] = 0;
      prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; prev_busy[i] = 1'b0;
      low_run[i] = 0; low_len[i] = 0; fall_cyc[i] = 0; fall_gap[i] = 0;
      busy_fall[i] = 0; valid_cnt[i] = 0; valid_cyc[i] = 0; miso[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (cs_n[i] !== 1'b0) begin
        s_edges[i]   = 0;
        prev_sclk[i] = sclk[i];
        miso[i]      = slave_frame[i][FB_I[i]-1];
      end else if (sclk[i] !== prev_sclk[i]) begin
        prev_sclk[i] = sclk[i];
        s_edges[i]++;
        if ((CPHA_I[i] == 0 && s_edges[i] % 2 == 1) || (CPHA_I[i] == 1 && s_edges[i] % 2 == 0)) begin
          samp_cnt[i]++;
          if (sclk[i] === 1'b1) samp_rise[i]++;
        end
        if (CPHA_I[i] == 1 && s_edges[i] % 2 == 1)
          miso[i] = slave_frame[i][FB_I[i]-1-(s_edges[i]-1)/2];
        else if (CPHA_I[i] == 0 && s_edges[i] % 2 == 0 && s_edges[i] < 2 * FB_I[i])
          miso[i] = slave_frame[i][FB_I[i]-1-s_edges[i]/2];
      end
      if (cs_n[i] === 1'b0) begin
        if (prev_cs[i] === 1'b1) begin
          fall_gap[i] = cyc - fall_cyc[i];
          fall_cyc[i] = cyc;
          low_run[i]  = 0;
          samp_cnt[i] = 0;
          samp_rise[i] = 0;
        end
        low_run[i]++;
      end else if (prev_cs[i] === 1'b0) begin
        low_len[i] = low_run[i];
      end
      prev_cs[i] = cs_n[i];
      if (busy[i] === 1'b0 && prev_busy[i] === 1'b1) busy_fall[i] = cyc;
      prev_busy[i] = busy[i];
      if (valid[i] === 1'b1) begin
        valid_cnt[i]++;
        valid_cyc[i] = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(i), 32'hFFFF_FFFF);
        end else begin
          logic [25:0] e;
          e = exp_q.pop_front();
          check("strobe_data_frame", {6'h0, 2'(i), data[i], frame_of(i)}, {6'h0, e});
        end
      end
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(int i);
    @(negedge clk) start[i] = 1'b1;
    @(negedge clk) start[i] = 1'b0;
  endtask

  task automatic wait_busy_low(int i, int budget);
    int k;
    k = 0;
    while (busy[i] !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) check("busy_low_timeout", 32'(i), 32'hFFFF_FFFF);
    wait_cycles(3);
  endtask

  task automatic run_single(int i, logic [15:0] f, logic [7:0] d, int low);
    int v0;
    slave_frame[i] = f;
    exp_q.push_back({2'(i), d, f});
    v0 = valid_cnt[i];
    pulse_start(i);
    wait_busy_low(i, 2000);
    check("valid_count", 32'(valid_cnt[i] - v0), 32'd1);
    check("cs_low_cycles", 32'(low_len[i]), 32'(low));
    check("busy_drop_after_valid", 32'(busy_fall[i] - valid_cyc[i]), 32'd7);
    check("sample_edges", 32'(samp_cnt[i]), 32'(FB_I[i]));
    check("sample_edges_rising", 32'(samp_rise[i]), 32'(FB_I[i]));
    check("state_idle", 32'(st[i]), 32'd0);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] frame;
    logic [7:0]  data;
    int          low;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int v0, k;
    vecs[0] = '{0, 16'h1FE0, 8'hFF, 166};
    vecs[1] = '{0, 16'h1234, 8'h91, 166};
    vecs[2] = '{0, 16'h0000, 8'h00, 166};
    vecs[3] = '{1, 16'h0A5C, 8'hA5, 126};
    vecs[4] = '{1, 16'h03C3, 8'h3C, 126};
    vecs[5] = '{2, 16'h5555, 8'hAA, 69};
    vecs[6] = '{2, 16'h1FE0, 8'hFF, 69};
    vecs[7] = '{0, 16'hFFFF, 8'hFF, 166};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; cont[i] = 1'b0;
    end
    wait_cycles(3);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    wait_cycles(2);
    for (int i = 0; i < 3; i++) begin
      check("reset_cs_n", 32'(cs_n[i]), 32'd1);
      check("reset_sclk", 32'(sclk[i]), 32'(CPOL_I[i]));
      check("reset_mosi", 32'(mosi[i]), 32'd0);
      check("reset_busy", 32'(busy[i]), 32'd0);
      check("reset_valid", 32'(valid[i]), 32'd0);
      check("reset_data", 32'(data[i]), 32'd0);
      check("reset_frame", 32'(frame_of(i)), 32'd0);
      check("reset_state", 32'(st[i]), 32'd0);
    end

    for (int n = 0; n < 8; n++)
      run_single(vecs[n].inst, vecs[n].frame, vecs[n].data, vecs[n].low);

    // continuous mode: two frames, drop continuous during the second
    slave_frame[0] = 16'h0A40;
    exp_q.push_back({2'd0, 8'h52, 16'h0A40});
    exp_q.push_back({2'd0, 8'hFF, 16'h1FE0});
    v0 = valid_cnt[0];
    @(negedge clk) cont[0] = 1'b1;
    k = 0;
    while (valid_cnt[0] == v0 && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) check("cont_first_timeout", 32'd0, 32'd1);
    slave_frame[0] = 16'h1FE0;
    k = 0;
    while (cs_n[0] !== 1'b0 && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) check("cont_second_cs_timeout", 32'd0, 32'd1);
    wait_cycles(2);
    check("cont_cs_fall_gap", 32'(fall_gap[0]), 32'd173);
    wait_cycles(60);
    cont[0] = 1'b0;
    wait_busy_low(0, 400);
    check("cont_valid_count", 32'(valid_cnt[0] - v0), 32'd2);
    wait_cycles(200);
    check("cont_stays_idle", 32'(valid_cnt[0] - v0), 32'd2);
    check("cont_cs_high", 32'(cs_n[0]), 32'd1);

    // two starts during a frame yield exactly one extra frame
    slave_frame[0] = 16'h1234;
    exp_q.push_back({2'd0, 8'h91, 16'h1234});
    exp_q.push_back({2'd0, 8'h91, 16'h1234});
    v0 = valid_cnt[0];
    pulse_start(0);
    wait_cycles(20);
    pulse_start(0);
    wait_cycles(20);
    pulse_start(0);
    wait_busy_low(0, 1000);
    check("double_start_valids", 32'(valid_cnt[0] - v0), 32'd2);

    // simultaneous start and continuous in IDLE: one frame, no pending
    slave_frame[0] = 16'h0A40;
    exp_q.push_back({2'd0, 8'h52, 16'h0A40});
    v0 = valid_cnt[0];
    @(negedge clk) begin start[0] = 1'b1; cont[0] = 1'b1; end
    @(negedge clk) begin start[0] = 1'b0; cont[0] = 1'b0; end
    wait_busy_low(0, 1000);
    wait_cycles(200);
    check("start_cont_single", 32'(valid_cnt[0] - v0), 32'd1);

    // reset mid-frame, then a clean frame
    slave_frame[0] = 16'h1FE0;
    v0 = valid_cnt[0];
    pulse_start(0);
    k = 0;
    while (s_edges[0] < 16 && k < 300) begin @(negedge clk); k++; end
    if (k >= 300) check("abort_edge_timeout", 32'd0, 32'd1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(cs_n[0]), 32'd1);
    check("abort_sclk", 32'(sclk[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_data", 32'(data[0]), 32'd0);
    check("abort_frame", 32'(frame_a), 32'd0);
    rst[0] = 1'b0;
    wait_cycles(200);
    check("abort_no_valid", 32'(valid_cnt[0] - v0), 32'd0);
    run_single(0, 16'h0A40, 8'h52, 166);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_adc_reader.md
# spi_adc_reader

Parametrised SPI master that reads fixed-length frames from a single-channel serial ADC, such as the ambient light sensor, and extracts a configurable data field. It generalises the fixed 16-bit / mode-3 sensor reader in four ways: SPI mode, frame length, field position and timing are parameters; it supports both single-shot and continuous conversion; and it adds a start/busy/valid handshake. It sits between the sensor pins and downstream consumers such as the PWM brightness driver and the 7-segment display logic.

## Interface
- CLKS_PER_HALF_BIT, 5: i_Clk cycles per SCLK half-period; legal range ≥2.
- CPOL, 1: SCLK idle level.
- CPHA, 1: sampling edge. 0 = leading edge (first edge away from CPOL); 1 = trailing edge.
- FRAME_BITS, 16: SCLK cycles per frame; legal range 2..64.
- DATA_MSB, 12: MSB of the extracted field within the frame (bit FRAME_BITS-1 is the first bit received).
- DATA_LSB, 5: LSB of the extracted field; DATA_LSB ≤ DATA_MSB < FRAME_BITS.
- CS_SETUP_CLKS, 1: cycles CS_n is held low before the first SCLK activity; legal range ≥1.
- QUIET_CLKS, 7: cycles CS_n is held high between frames; legal range ≥1.
- i_Clk  in  1  system clock; the only clock.
- i_Rst  in  1  reset; synchronous, active-high.
- i_Start  in  1  one-cycle request for one frame.
- i_Continuous  in  1  while high, frames repeat back-to-back.
- o_Busy  out  1  high while a frame or its quiet gap is in progress.
- o_Data  out  DATA_MSB-DATA_LSB+1  last extracted field.
- o_Frame  out  FRAME_BITS  last full raw frame.
- o_Data_Valid  out  1  one-cycle strobe marking new o_Data and o_Frame.
- o_SPI_Clk  out  1  SCLK.
- o_SPI_CS_n  out  1  chip select, active low.
- o_SPI_MOSI  out  1  constant 0; the ADC is read-only.
- i_SPI_MISO  in  1  serial data from the ADC.

## Operation
- Reset values:
  - o_SPI_Clk = CPOL, o_SPI_CS_n = 1, o_SPI_MOSI = 0.
  - o_Busy = 0, o_Data_Valid = 0, o_Data = 0, o_Frame = 0.
  - State = IDLE; the pending-start flag is cleared.
- States:
  - IDLE → SETUP: on i_Start=1 or i_Continuous=1.
  - SETUP: lasts CS_SETUP_CLKS cycles, then → SHIFT.
  - SHIFT: shifts in FRAME_BITS bits, then → QUIET.
  - QUIET: lasts QUIET_CLKS cycles, then → SETUP if i_Continuous=1 or a start is pending; otherwise → IDLE.
- CS_n is low throughout SETUP and SHIFT, and high in IDLE and QUIET.
- SHIFT sequence:
  - SCLK is held at CPOL for CLKS_PER_HALF_BIT cycles.
  - It then toggles every CLKS_PER_HALF_BIT cycles for exactly 2×FRAME_BITS edges.
  - After the final edge (which returns SCLK to CPOL), SCLK holds for CLKS_PER_HALF_BIT more cycles before the transition to QUIET.
- Sampling:
  - On each sampling edge (leading edge if CPHA=0, trailing edge if CPHA=1), i_SPI_MISO is registered on the same i_Clk edge that changes o_SPI_Clk.
  - Bits arrive MSB first into a FRAME_BITS shift register.
- Frame completion, on the cycle CS_n rises (SHIFT→QUIET):
  - o_Frame ← the shift register.
  - o_Data ← shift register[DATA_MSB:DATA_LSB].
  - o_Data_Valid = 1 for exactly that cycle.
- Start handling:
  - An i_Start while o_Busy=1 sets a one-deep pending flag; further starts while the flag is set are dropped.
  - The flag clears when the next SETUP is entered.
- i_Continuous is sampled only at the IDLE and QUIET decision points. Dropping it mid-frame finishes the current frame, then returns to IDLE unless a start is pending.
- Simultaneous i_Start and i_Continuous in IDLE produce a single frame entry; no pending flag is set.
- i_Rst mid-frame: on the next cycle all outputs take their reset values. CS_n returns high, and no o_Data_Valid is emitted for the aborted frame.

## Timing
- i_Start at cycle 0 (IDLE): CS_n=0 and o_Busy=1 from cycle 1.
- CS_n low duration: CS_SETUP_CLKS + (2×FRAME_BITS+1)×CLKS_PER_HALF_BIT cycles. With defaults this is 166.
- o_Data_Valid asserts on the first cycle CS_n is high again.
- o_Busy:
  - Stays high through QUIET.
  - Drops on the cycle IDLE is re-entered, i.e. QUIET_CLKS cycles after o_Data_Valid.
- Continuous mode: CS_n falling edges are 166 + QUIET_CLKS = 173 cycles apart with defaults.
- Outputs hold their values between strobes.

## Test plan
- Defaults, single i_Start, MISO driving frame 0x1FE0 → one o_Data_Valid with o_Data=0xFF, o_Frame=0x1FE0; CS_n low for 166 cycles; o_Busy low again 7 cycles after the strobe; exactly 16 sampling edges, all rising.
- Defaults, i_Continuous=1, frames 0x0A40 then 0x1FE0 → o_Data=0x52 then 0xFF; CS_n falling edges 173 cycles apart; i_Continuous dropped mid-second-frame → the second frame completes, then IDLE.
- i_Start pulsed twice during a frame → exactly one extra frame follows; o_Data_Valid count = 2.
- CPOL=0, CPHA=0, FRAME_BITS=12, DATA_MSB=11, DATA_LSB=4, frame 0xA5C → SCLK idles low, samples on rising (leading) edges, o_Data=0xA5.
- i_Rst asserted at bit 8 of a frame → next cycle CS_n=1, SCLK=CPOL, o_Busy=0, o_Data=0; no o_Data_Valid; a following i_Start runs a clean full frame.
- CLKS_PER_HALF_BIT=2, CS_SETUP_CLKS=3 → CS_n low for 3 + 33×2 = 69 cycles; data captured correctly.
